// File: rtl/if_fetch_unit_if.sv
// Bundle of the fetch unit's memory-port, redirect and decode-side signals.
// The master modport is the fetch unit's view; slave is the memory/decode environment.
interface if_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_gnt;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;
    logic [7:0]            mem_din;
    logic                  jump_en;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic                  id_ready;
    logic                  if_valid;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic [31:0]           if_inst;

    modport master (
        output mem_req, mem_a, mem_wr, if_valid, if_pc, if_inst,
        input  mem_gnt, mem_din, jump_en, jump_target, id_ready
    );

    modport slave (
        input  mem_req, mem_a, mem_wr, if_valid, if_pc, if_inst,
        output mem_gnt, mem_din, jump_en, jump_target, id_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: assembles a 32-bit little-endian instruction from four byte
// reads (one-cycle read latency) and holds it in a valid/ready register for decode.
module if_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    if_fetch_unit_if.master bus
);
    typedef enum logic {FETCH, HOLD} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic                  mem_req_q, mem_req_d;
    logic [2:0]            issue_ptr_q, issue_ptr_d;
    logic [2:0]            cap_ptr_q, cap_ptr_d;
    logic                  inflight_q, inflight_d;
    logic                  if_valid_q, if_valid_d;
    logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [31:0]           if_inst_q, if_inst_d;
    logic [7:0]            lane_q [3];
    logic [7:0]            lane_d [3];

    logic                  issue, capture, xfer, jump;
    logic [ADDR_WIDTH-1:0] jump_pc, pc_plus4;

    assign issue    = rdy_in && bus.mem_gnt && mem_req_q;
    assign capture  = rdy_in && inflight_q;
    assign xfer     = rdy_in && if_valid_q && bus.id_ready;
    assign jump     = rdy_in && bus.jump_en;
    assign jump_pc  = bus.jump_target & ~ADDR_WIDTH'(3);
    assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

    // Bytes 0..2 are parked here; byte 3 goes straight from mem_din into if_inst.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            assign lane_d[gi] = (capture && cap_ptr_q == 3'(gi)) ? bus.mem_din : lane_q[gi];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_a_d     = mem_a_q;
        mem_req_d   = mem_req_q;
        issue_ptr_d = issue_ptr_q;
        cap_ptr_d   = cap_ptr_q;
        inflight_d  = inflight_q;
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;

        if (!rdy_in) begin
            // Data returning during a pause is dropped; rewind so that byte is reissued.
            if (inflight_q) begin
                issue_ptr_d = cap_ptr_q;
                inflight_d  = 1'b0;
                mem_req_d   = 1'b1;
                mem_a_d     = pc_q + ADDR_WIDTH'(cap_ptr_q);
            end
        end else if (jump) begin
            pc_d        = jump_pc;
            state_d     = FETCH;
            issue_ptr_d = '0;
            cap_ptr_d   = '0;
            inflight_d  = 1'b0;
            if_valid_d  = 1'b0;
            mem_req_d   = 1'b1;
            mem_a_d     = jump_pc;
        end else if (state_q == HOLD) begin
            if (xfer) begin
                pc_d        = pc_plus4;
                state_d     = FETCH;
                issue_ptr_d = '0;
                cap_ptr_d   = '0;
                if_valid_d  = 1'b0;
                mem_req_d   = 1'b1;
                mem_a_d     = pc_plus4;
            end
        end else begin
            issue_ptr_d = issue_ptr_q + 3'(issue);
            inflight_d  = issue;
            if (capture) begin
                cap_ptr_d = cap_ptr_q + 3'd1;
                if (cap_ptr_q == 3'd3) begin
                    state_d     = HOLD;
                    if_valid_d  = 1'b1;
                    if_inst_d   = {bus.mem_din, lane_q[2], lane_q[1], lane_q[0]};
                    if_pc_d     = pc_q;
                    cap_ptr_d   = '0;
                    issue_ptr_d = '0;
                end
            end
            mem_req_d = (state_d == FETCH) && (issue_ptr_d < 3'd4);
            if (mem_req_d) begin
                mem_a_d = pc_q + ADDR_WIDTH'(issue_ptr_d);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            mem_a_q     <= '0;
            mem_req_q   <= 1'b0;
            issue_ptr_q <= '0;
            cap_ptr_q   <= '0;
            inflight_q  <= 1'b0;
            if_valid_q  <= 1'b0;
            if_pc_q     <= '0;
            if_inst_q   <= '0;
            for (int i = 0; i < 3; i++) lane_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_a_q     <= mem_a_d;
            mem_req_q   <= mem_req_d;
            issue_ptr_q <= issue_ptr_d;
            cap_ptr_q   <= cap_ptr_d;
            inflight_q  <= inflight_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
            for (int i = 0; i < 3; i++) lane_q[i] <= lane_d[i];
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_wr   = 1'b0;
    assign bus.if_valid = if_valid_q;
    assign bus.if_pc    = if_pc_q;
    assign bus.if_inst  = if_inst_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by a randomized run checked
// against an instruction-stream model (expected PC sequence plus byte-addressed memory).
module tb_if_fetch_unit;
    localparam int AW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rdy   = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    if_fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();

    if_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] r;
        case (a)
            32'd0:   r = 8'h13;
            32'd1:   r = 8'h05;
            32'd2:   r = 8'h10;
            32'd3:   r = 8'h00;
            default: r = a[7:0] ^ {a[12:8], a[15:13]} ^ a[31:24] ^ 8'h6C;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    // Memory returns the byte for the address seen at the previous edge.
    always @(posedge clk) bus.mem_din <= mem_byte(bus.mem_a);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b1;
        bus.mem_gnt = 1'b1; bus.id_ready = 1'b0; bus.jump_en = 1'b0; bus.jump_target = '0;
        repeat (3) cyc();
        tests_run++;
        if ({bus.if_valid, bus.mem_req, bus.mem_wr} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got valid=%b req=%b wr=%b required 0 0 0", bus.if_valid, bus.mem_req, bus.mem_wr);
        end
        tests_run++;
        if (bus.mem_a !== 32'h0 || bus.if_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_addr: got mem_a=%h if_pc=%h required 0 0", bus.mem_a, bus.if_pc);
        end
        tests_run++;
        if (bus.if_inst !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_inst: got %h required 00000000", bus.if_inst);
        end
    endtask

    task automatic test_first_fetch();
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (i <= 4) begin
                tests_run++;
                if (bus.mem_req !== 1'b1 || bus.mem_a !== 32'(i - 1)) begin
                    tests_failed++;
                    $display("FAIL first_fetch_addr c%0d: got req=%b a=%h required 1 %h", i, bus.mem_req, bus.mem_a, 32'(i - 1));
                end
            end else if (i == 5) begin
                tests_run++;
                if (bus.if_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL first_fetch_early_valid: got %b required 0", bus.if_valid);
                end
            end
        end
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_inst !== 32'h00100513 || bus.if_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL first_fetch_out: got v=%b inst=%h pc=%h required 1 00100513 0", bus.if_valid, bus.if_inst, bus.if_pc);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 7; i <= 11; i++) begin
            cyc();
            tests_run++;
            if (bus.if_valid !== 1'b1 || bus.if_inst !== 32'h00100513 || bus.if_pc !== 32'h0 || bus.mem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_stable c%0d: got v=%b inst=%h pc=%h req=%b required 1 00100513 0 0", i, bus.if_valid, bus.if_inst, bus.if_pc, bus.mem_req);
            end
        end
        bus.id_ready = 1'b1;
        cyc();
        bus.id_ready = 1'b0;
        tests_run++;
        if (bus.if_valid !== 1'b0 || bus.mem_a !== 32'h4 || bus.mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL handshake_next: got v=%b a=%h req=%b required 0 4 1", bus.if_valid, bus.mem_a, bus.mem_req);
        end
    endtask

    // Entry: cycle in which byte0 of 'base' is being issued.
    task automatic test_gnt_stall(input logic [31:0] base);
        cyc(); cyc();
        tests_run++;
        if (bus.mem_a !== base + 32'd2) begin
            tests_failed++;
            $display("FAIL gnt_byte2_due: got %h required %h", bus.mem_a, base + 32'd2);
        end
        bus.mem_gnt = 1'b0;
        cyc();
        bus.mem_gnt = 1'b1;
        tests_run++;
        if (bus.mem_a !== base + 32'd2 || bus.mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL gnt_hold_addr: got a=%h req=%b required %h 1", bus.mem_a, bus.mem_req, base + 32'd2);
        end
        cyc();
        tests_run++;
        if (bus.mem_a !== base + 32'd3) begin
            tests_failed++;
            $display("FAIL gnt_byte3: got %h required %h", bus.mem_a, base + 32'd3);
        end
        cyc();
        tests_run++;
        if (bus.if_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL gnt_valid_early: got %b required 0", bus.if_valid);
        end
        cyc();
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_inst !== exp_word(base) || bus.if_pc !== base) begin
            tests_failed++;
            $display("FAIL gnt_out: got v=%b inst=%h pc=%h required 1 %h %h", bus.if_valid, bus.if_inst, bus.if_pc, exp_word(base), base);
        end
        bus.id_ready = 1'b1;
        cyc();
        bus.id_ready = 1'b0;
    endtask

    task automatic test_rdy_pause(input logic [31:0] base);
        cyc(); cyc();
        rdy = 1'b0;
        cyc();
        bus.jump_en = 1'b1; bus.jump_target = 32'h0000_3000;
        cyc();
        bus.jump_en = 1'b0;
        cyc();
        rdy = 1'b1;
        tests_run++;
        if (bus.mem_a !== base + 32'd1 || bus.mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL pause_reissue: got a=%h req=%b required %h 1", bus.mem_a, bus.mem_req, base + 32'd1);
        end
        cyc(); cyc(); cyc();
        tests_run++;
        if (bus.if_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL pause_valid_early: got %b required 0", bus.if_valid);
        end
        cyc();
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_inst !== exp_word(base) || bus.if_pc !== base) begin
            tests_failed++;
            $display("FAIL pause_out: got v=%b inst=%h pc=%h required 1 %h %h", bus.if_valid, bus.if_inst, bus.if_pc, exp_word(base), base);
        end
        bus.id_ready = 1'b1;
        cyc();
        bus.id_ready = 1'b0;
        tests_run++;
        if (bus.if_valid !== 1'b0 || bus.mem_a !== base + 32'd4) begin
            tests_failed++;
            $display("FAIL pause_next: got v=%b a=%h required 0 %h", bus.if_valid, bus.mem_a, base + 32'd4);
        end
    endtask

    task automatic test_jump();
        cyc(); cyc();
        bus.jump_en = 1'b1; bus.jump_target = 32'h0000_1006;
        cyc();
        bus.jump_en = 1'b0;
        tests_run++;
        if (bus.if_valid !== 1'b0 || bus.mem_a !== 32'h0000_1004 || bus.mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL jump_redirect: got v=%b a=%h req=%b required 0 00001004 1", bus.if_valid, bus.mem_a, bus.mem_req);
        end
        repeat (4) cyc();
        tests_run++;
        if (bus.if_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL jump_valid_early: got %b required 0", bus.if_valid);
        end
        cyc();
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_inst !== exp_word(32'h1004) || bus.if_pc !== 32'h1004) begin
            tests_failed++;
            $display("FAIL jump_out: got v=%b inst=%h pc=%h required 1 %h 00001004", bus.if_valid, bus.if_inst, bus.if_pc, exp_word(32'h1004));
        end
        bus.id_ready = 1'b1; bus.jump_en = 1'b1; bus.jump_target = 32'h0000_2000;
        cyc();
        bus.id_ready = 1'b0; bus.jump_en = 1'b0;
        tests_run++;
        if (bus.if_valid !== 1'b0 || bus.mem_a !== 32'h0000_2000) begin
            tests_failed++;
            $display("FAIL jump_with_xfer: got v=%b a=%h required 0 00002000", bus.if_valid, bus.mem_a);
        end
    endtask

    task automatic test_pc_wrap();
        bus.jump_en = 1'b1; bus.jump_target = 32'hFFFF_FFFF;
        cyc();
        bus.jump_en = 1'b0;
        tests_run++;
        if (bus.mem_a !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_start: got %h required fffffffc", bus.mem_a);
        end
        repeat (3) cyc();
        tests_run++;
        if (bus.mem_a !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL wrap_byte3: got %h required ffffffff", bus.mem_a);
        end
        repeat (2) cyc();
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_inst !== exp_word(32'hFFFF_FFFC) || bus.if_pc !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_out: got v=%b inst=%h pc=%h required 1 %h fffffffc", bus.if_valid, bus.if_inst, bus.if_pc, exp_word(32'hFFFF_FFFC));
        end
        bus.id_ready = 1'b1;
        cyc();
        bus.id_ready = 1'b0;
        tests_run++;
        if (bus.if_valid !== 1'b0 || bus.mem_a !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_next_pc: got v=%b a=%h required 0 0", bus.if_valid, bus.mem_a);
        end
        repeat (5) cyc();
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_inst !== 32'h00100513 || bus.if_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_refetch: got v=%b inst=%h pc=%h required 1 00100513 0", bus.if_valid, bus.if_inst, bus.if_pc);
        end
        bus.id_ready = 1'b1;
        cyc();
        bus.id_ready = 1'b0;
    endtask

    task automatic test_reset_midfetch();
        cyc(); cyc();
        rdy = 1'b0; rst_n = 1'b0;
        cyc();
        tests_run++;
        if ({bus.if_valid, bus.mem_req, bus.mem_wr} !== 3'b000 || bus.mem_a !== 32'h0 || bus.if_pc !== 32'h0 || bus.if_inst !== 32'h0) begin
            tests_failed++;
            $display("FAIL midfetch_reset: got v=%b req=%b wr=%b a=%h pc=%h inst=%h required all zero", bus.if_valid, bus.mem_req, bus.mem_wr, bus.mem_a, bus.if_pc, bus.if_inst);
        end
        rst_n = 1'b1; rdy = 1'b1;
        cyc();
        tests_run++;
        if (bus.mem_a !== 32'h0 || bus.mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL midfetch_restart: got a=%h req=%b required 0 1", bus.mem_a, bus.mem_req);
        end
        repeat (5) cyc();
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_inst !== 32'h00100513 || bus.if_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL midfetch_out: got v=%b inst=%h pc=%h required 1 00100513 0", bus.if_valid, bus.if_inst, bus.if_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        bit          expect_idle;
        int          xfers;
        int          idle;
        rst_n = 1'b0; rdy = 1'b1; bus.jump_en = 1'b0; bus.id_ready = 1'b0; bus.mem_gnt = 1'b1;
        cyc(); cyc();
        rst_n = 1'b1;
        exp_pc = 32'h0; expect_idle = 1'b0; xfers = 0; idle = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (expect_idle) begin
                tests_run++;
                if (bus.if_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rand_valid_after_xfer c%0d: got %b required 0", c, bus.if_valid);
                end
            end
            rdy             = ($urandom_range(9) != 0);
            bus.mem_gnt     = ($urandom_range(9) < 7);
            bus.id_ready    = ($urandom_range(1) == 1);
            bus.jump_en     = ($urandom_range(49) == 0);
            bus.jump_target = ($urandom_range(3) == 0) ? 32'($urandom) : 32'($urandom_range(1023));
            expect_idle = 1'b0;
            if (rdy) begin
                if (bus.if_valid === 1'b1 && bus.id_ready) begin
                    tests_run++;
                    if (bus.if_pc !== exp_pc || bus.if_inst !== exp_word(exp_pc)) begin
                        tests_failed++;
                        $display("FAIL rand_xfer c%0d: got pc=%h inst=%h required %h %h", c, bus.if_pc, bus.if_inst, exp_pc, exp_word(exp_pc));
                    end
                    xfers++;
                    idle = 0;
                    exp_pc = exp_pc + 32'd4;
                    expect_idle = 1'b1;
                end
                if (bus.jump_en) begin
                    exp_pc = {bus.jump_target[31:2], 2'b00};
                    expect_idle = 1'b1;
                end
            end
            idle++;
            if (idle > 300) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rand_watchdog c%0d: got no transfer for %0d cycles required at most 300", c, idle);
                break;
            end
        end
        rdy = 1'b1; bus.jump_en = 1'b0; bus.id_ready = 1'b0;
        tests_run++;
        if (xfers < 20) begin
            tests_failed++;
            $display("FAIL rand_throughput: got %0d transfers required at least 20", xfers);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_gnt_stall(32'h4);
        test_rdy_pause(32'h8);
        test_jump();
        test_pc_wrap();
        test_reset_midfetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
